// File: rtl/fft_seq_pkg.sv
// Shared types, constants and width helpers for the FFT sequencer slice.
package fft_seq_pkg;

  localparam int unsigned FLUSH_CYCLES = 4;
  localparam int unsigned FLUSH_W      = 2;

  localparam int unsigned CE_DIV_DEF = 25;
  localparam int unsigned LGFFT_DEF  = 10;
  localparam int unsigned IW_DEF     = 16;
  localparam int unsigned OW_DEF     = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_e;

  typedef enum logic {
    TRK_WAIT    = 1'b0,
    TRK_COLLECT = 1'b1
  } trk_state_e;

  // Bin index width for an FFT of 2**lgfft points.
  function automatic int unsigned bin_w(input int unsigned lgfft);
    return lgfft;
  endfunction

  // |re|+|im| needs one bit more than a single component.
  function automatic int unsigned mag_w(input int unsigned ow);
    return ow + 1;
  endfunction

  // Divider counter width; at least one bit.
  function automatic int unsigned div_w(input int unsigned ce_div);
    return (ce_div > 1) ? $clog2(ce_div) : 1;
  endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// Sample handshake, fftmain-facing and peak-report signals of the sequencer.
interface fft_sequencer_if #(
  parameter int unsigned IW    = fft_seq_pkg::IW_DEF,
  parameter int unsigned OW    = fft_seq_pkg::OW_DEF,
  parameter int unsigned LGFFT = fft_seq_pkg::LGFFT_DEF
);
  import fft_seq_pkg::*;

  logic                    i_sample_valid;
  logic [IW-1:0]           i_sample;
  logic                    o_sample_ready;
  logic                    o_fft_reset;
  logic                    o_fft_ce;
  logic [IW-1:0]           o_fft_sample;
  logic [2*OW-1:0]         i_fft_result;
  logic                    i_fft_sync;
  logic                    o_peak_valid;
  logic [bin_w(LGFFT)-1:0] o_peak_bin;
  logic [mag_w(OW)-1:0]    o_peak_mag;
  logic                    o_underrun;
  logic                    o_sync_err;

  // Environment side: ADC front end, fftmain and the report consumer.
  modport master (
    output i_sample_valid, i_sample, i_fft_result, i_fft_sync,
    input  o_sample_ready, o_fft_reset, o_fft_ce, o_fft_sample,
           o_peak_valid, o_peak_bin, o_peak_mag, o_underrun, o_sync_err
  );

  // Sequencer side.
  modport slave (
    input  i_sample_valid, i_sample, i_fft_result, i_fft_sync,
    output o_sample_ready, o_fft_reset, o_fft_ce, o_fft_sample,
           o_peak_valid, o_peak_bin, o_peak_mag, o_underrun, o_sync_err
  );

endinterface

// File: rtl/fft_mag_abs.sv
// |re|+|im| of a packed {re, im} signed result word, registered once.
module fft_mag_abs
  import fft_seq_pkg::*;
#(
  parameter int unsigned OW = OW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*OW-1:0]      result,
  output logic [mag_w(OW)-1:0] mag
);

  localparam int unsigned MW = mag_w(OW);

  logic [OW-1:0] re_c;
  logic [OW-1:0] im_c;
  logic [OW-1:0] abs_re_c;
  logic [OW-1:0] abs_im_c;
  logic [MW-1:0] mag_c;

  // Two's-complement abs; the most negative value maps to 2**(OW-1) unsigned.
  always_comb begin
    re_c     = result[2*OW-1:OW];
    im_c     = result[OW-1:0];
    abs_re_c = re_c[OW-1] ? (~re_c + OW'(1)) : re_c;
    abs_im_c = im_c[OW-1] ? (~im_c + OW'(1)) : im_c;
    mag_c    = MW'(abs_re_c) + MW'(abs_im_c);
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
    end else begin
      mag <= mag_c;
    end
  end

endmodule

// File: rtl/fft_sequencer.sv
// Paces fftmain at the sample rate, buffers ADC samples and reports the
// dominant positive-frequency bin of every completed output frame.
module fft_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned CE_DIV = CE_DIV_DEF,
  parameter int unsigned LGFFT  = LGFFT_DEF,
  parameter int unsigned IW     = IW_DEF,
  parameter int unsigned OW     = OW_DEF
) (
  input logic          i_clk,
  input logic          i_reset_n,
  input logic          i_enable,
  fft_sequencer_if.slave bus
);

  localparam int unsigned DIV_W = div_w(CE_DIV);
  localparam int unsigned BW    = bin_w(LGFFT);
  localparam int unsigned MW    = mag_w(OW);

  localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CE_DIV - 1);
  localparam logic [BW-1:0]    BIN_FIRST     = BW'(1);
  localparam logic [BW-1:0]    BIN_HALF_LAST = BW'((1 << (LGFFT - 1)) - 1);
  localparam logic [BW-1:0]    BIN_LAST      = BW'((1 << LGFFT) - 1);

  // ---------------- control FSM ----------------
  seq_state_e          state_q, state_d;
  logic [FLUSH_W-1:0]  flush_q, flush_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                fft_reset_q, fft_reset_d;
  logic                fft_ce_q, fft_ce_d;
  logic                clear_flags_c;

  // Control state, flush counter, divider and the fftmain-facing controls.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      flush_q     <= '0;
      div_q       <= '0;
      fft_reset_q <= 1'b1;
      fft_ce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      div_q       <= div_d;
      fft_reset_q <= fft_reset_d;
      fft_ce_q    <= fft_ce_d;
    end
  end

  // Next state: fftmain held in reset outside RUN, strobe on divider wrap.
  always_comb begin
    state_d       = state_q;
    flush_d       = '0;
    div_d         = '0;
    fft_reset_d   = 1'b1;
    fft_ce_d      = 1'b0;
    clear_flags_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          state_d       = ST_FLUSH;
          clear_flags_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (flush_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
          state_d     = ST_RUN;
          fft_reset_d = 1'b0;
        end else begin
          flush_d = flush_q + FLUSH_W'(1);
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else begin
          fft_reset_d = 1'b0;
          fft_ce_d    = (div_q == DIV_LAST);
          div_d       = fft_ce_d ? '0 : div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------- sample holding register ----------------
  logic          ready_q, ready_d;
  logic [IW-1:0] sample_q;
  logic          underrun_q;
  logic          take_c;

  // A new handshake wins over the strobe's clear so a same-cycle load is kept.
  always_comb begin
    take_c  = bus.i_sample_valid && ready_q;
    ready_d = ready_q;
    if (take_c) begin
      ready_d = 1'b0;
    end else if (fft_ce_q) begin
      ready_d = 1'b1;
    end
  end

  // Holding register, ready flag and sticky underrun.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ready_q    <= 1'b1;
      sample_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
      if (take_c) begin
        sample_q <= bus.i_sample;
      end
      if (clear_flags_c) begin
        underrun_q <= 1'b0;
      end else if (fft_ce_q && ready_q) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // ---------------- frame tracker ----------------
  trk_state_e    trk_q, trk_d;
  logic [BW-1:0] bin_q, bin_d;
  logic          s1_valid_q, s1_valid_d;
  logic [BW-1:0] s1_bin_q, s1_bin_d;
  logic          sync_err_q;
  logic          sync_err_set_c;
  logic          run_c;
  logic          sample_c;

  // Tracker state and the bin index travelling alongside the magnitude.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      trk_q      <= TRK_WAIT;
      bin_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      trk_q      <= trk_d;
      bin_q      <= bin_d;
      s1_valid_q <= s1_valid_d;
      s1_bin_q   <= s1_bin_d;
      if (clear_flags_c) begin
        sync_err_q <= 1'b0;
      end else if (sync_err_set_c) begin
        sync_err_q <= 1'b1;
      end
    end
  end

  // Bin counting from sync; a sync inside an unfinished frame restarts it.
  always_comb begin
    run_c          = (state_q == ST_RUN) && i_enable;
    sample_c       = fft_ce_q && run_c;
    trk_d          = trk_q;
    bin_d          = bin_q;
    s1_valid_d     = 1'b0;
    s1_bin_d       = s1_bin_q;
    sync_err_set_c = 1'b0;
    if (!run_c) begin
      trk_d = TRK_WAIT;
      bin_d = '0;
    end else if (sample_c) begin
      if (bus.i_fft_sync) begin
        if (trk_q == TRK_COLLECT && bin_q < BIN_LAST) begin
          sync_err_set_c = 1'b1;
        end
        trk_d      = TRK_COLLECT;
        bin_d      = '0;
        s1_valid_d = 1'b1;
        s1_bin_d   = '0;
      end else if (trk_q == TRK_COLLECT) begin
        bin_d      = bin_q + BW'(1);
        s1_valid_d = 1'b1;
        s1_bin_d   = bin_q + BW'(1);
        if (bin_q + BW'(1) == BIN_LAST) begin
          trk_d = TRK_WAIT;
        end
      end
    end
  end

  // ---------------- magnitude and peak search ----------------
  logic [MW-1:0] mag_q;
  logic [MW-1:0] pk_mag_q;
  logic [BW-1:0] pk_bin_q;
  logic          peak_valid_q;
  logic [BW-1:0] peak_bin_q;
  logic [MW-1:0] peak_mag_q;
  logic          proc_c;

  fft_mag_abs #(
    .OW (OW)
  ) u_mag (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .result (bus.i_fft_result),
    .mag    (mag_q)
  );

  assign proc_c = s1_valid_q && run_c;

  // Positive-frequency peak search; the last bin publishes the frame result.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pk_mag_q     <= '0;
      pk_bin_q     <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      peak_valid_q <= 1'b0;
      if (proc_c) begin
        if (s1_bin_q == BIN_FIRST) begin
          pk_mag_q <= mag_q;
          pk_bin_q <= s1_bin_q;
        end else if (s1_bin_q > BIN_FIRST && s1_bin_q <= BIN_HALF_LAST &&
                     mag_q > pk_mag_q) begin
          pk_mag_q <= mag_q;
          pk_bin_q <= s1_bin_q;
        end
        if (s1_bin_q == BIN_LAST) begin
          peak_valid_q <= 1'b1;
          peak_bin_q   <= pk_bin_q;
          peak_mag_q   <= pk_mag_q;
        end
      end
    end
  end

  assign bus.o_sample_ready = ready_q;
  assign bus.o_fft_reset    = fft_reset_q;
  assign bus.o_fft_ce       = fft_ce_q;
  assign bus.o_fft_sample   = sample_q;
  assign bus.o_peak_valid   = peak_valid_q;
  assign bus.o_peak_bin     = peak_bin_q;
  assign bus.o_peak_mag     = peak_mag_q;
  assign bus.o_underrun     = underrun_q;
  assign bus.o_sync_err     = sync_err_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer with a 16-point frame and CE_DIV=25.
module tb_fft_sequencer;

  localparam int unsigned CE_DIV = 25;
  localparam int unsigned LGFFT  = 4;
  localparam int unsigned IW     = 16;
  localparam int unsigned OW     = 11;
  localparam int          NB     = 16;

  typedef struct {
    logic [3:0]  bin;
    logic [11:0] mag;
  } peak_t;

  logic clk;
  logic rst_n;
  logic enable;

  fft_sequencer_if #(.IW(IW), .OW(OW), .LGFFT(LGFFT)) bus ();

  fft_sequencer #(
    .CE_DIV (CE_DIV),
    .LGFFT  (LGFFT),
    .IW     (IW),
    .OW     (OW)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_enable  (enable),
    .bus       (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          prev_ce = -1;
  int          last_feed_cyc = 0;
  bit          ur_m = 1'b0;
  logic [15:0] last_s = 16'h0000;
  logic [15:0] samp_q[$];
  peak_t       exp_q[$];
  int          fr_re[NB];
  int          fr_im[NB];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Strobe monitor: period, sample scoreboard and underrun model.
  always @(negedge clk) begin
    if (rst_n && bus.o_fft_ce) begin
      if (prev_ce >= 0) chk("ce_period", 64'(cyc - prev_ce), 64'(CE_DIV));
      prev_ce = cyc;
      chk("underrun_at_strobe", 64'(bus.o_underrun), 64'(ur_m));
      if (samp_q.size() > 0) last_s = samp_q.pop_front();
      else ur_m = 1'b1;
      chk("fft_sample", 64'(bus.o_fft_sample), 64'(last_s));
    end
  end

  // Peak monitor: pops the scoreboard on each report pulse.
  always @(negedge clk) begin
    peak_t e;
    if (rst_n && bus.o_peak_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_peak_valid", 64'(bus.o_peak_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("peak_bin", 64'(bus.o_peak_bin), 64'(e.bin));
        chk("peak_mag", 64'(bus.o_peak_mag), 64'(e.mag));
        chk("peak_latency", 64'(cyc - last_feed_cyc), 64'd2);
      end
    end
  end

  function automatic int mag_of(input int re, input int im);
    return ((re < 0) ? -re : re) + ((im < 0) ? -im : im);
  endfunction

  task automatic fill_small();
    for (int b = 0; b < NB; b++) begin
      fr_re[b] = int'($urandom_range(20, 0)) - 10;
      fr_im[b] = int'($urandom_range(20, 0)) - 10;
    end
  endtask

  task automatic offer(input logic [15:0] s);
    int n = 0;
    bit hs = 1'b0;
    @(negedge clk);
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = s;
    while (!hs && n < 100) begin
      hs = bus.o_sample_ready;
      @(posedge clk);
      n++;
    end
    #1;
    bus.i_sample_valid = 1'b0;
    chk("offer_accepted", 64'(hs), 64'd1);
    if (hs) samp_q.push_back(s);
  endtask

  task automatic wait_strobe();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_fft_ce && n < 100);
    chk("strobe_seen", 64'(bus.o_fft_ce), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Present one result word and hold it through the next strobe.
  task automatic feed(input bit sync, input int re, input int im);
    logic [10:0] r;
    logic [10:0] i;
    int n = 0;
    r = 11'(re);
    i = 11'(im);
    bus.i_fft_result = {r, i};
    bus.i_fft_sync   = sync;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_fft_ce && n < 100);
    chk("feed_strobe", 64'(bus.o_fft_ce), 64'd1);
    last_feed_cyc = cyc;
    @(posedge clk);
    #1;
    bus.i_fft_sync = 1'b0;
  endtask

  task automatic send_frame(input int nbins, input bit push);
    peak_t e;
    int best_b;
    int best_m;
    if (push) begin
      best_b = 1;
      best_m = mag_of(fr_re[1], fr_im[1]);
      for (int b = 2; b < NB / 2; b++) begin
        if (mag_of(fr_re[b], fr_im[b]) > best_m) begin
          best_m = mag_of(fr_re[b], fr_im[b]);
          best_b = b;
        end
      end
      e.bin = 4'(best_b);
      e.mag = 12'(best_m);
      exp_q.push_back(e);
    end
    for (int b = 0; b < nbins; b++) feed(b == 0, fr_re[b], fr_im[b]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_ce = -1;
    rst_n              = 1'b0;
    enable             = 1'b0;
    bus.i_sample_valid = 1'b0;
    bus.i_sample       = '0;
    bus.i_fft_result   = '0;
    bus.i_fft_sync     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fft_reset", 64'(bus.o_fft_reset), 64'd1);
    chk("rst_ready", 64'(bus.o_sample_ready), 64'd1);
    chk("rst_ce", 64'(bus.o_fft_ce), 64'd0);
    chk("rst_sample", 64'(bus.o_fft_sample), 64'd0);
    chk("rst_peak_valid", 64'(bus.o_peak_valid), 64'd0);
    chk("rst_peak_bin", 64'(bus.o_peak_bin), 64'd0);
    chk("rst_peak_mag", 64'(bus.o_peak_mag), 64'd0);
    chk("rst_underrun", 64'(bus.o_underrun), 64'd0);
    chk("rst_sync_err", 64'(bus.o_sync_err), 64'd0);
    rst_n = 1'b1;

    // Preload a sample while idle, then start and time the first strobe.
    offer(16'h8100);
    chk("ready_after_load", 64'(bus.o_sample_ready), 64'd0);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 3) chk("fft_reset_in_flush", 64'(bus.o_fft_reset), 64'd1);
      if (k == 4) chk("fft_reset_in_run", 64'(bus.o_fft_reset), 64'd0);
      if (bus.o_fft_ce) begin
        first_ce = k;
        break;
      end
      @(posedge clk);
    end
    chk("first_ce_cycle", 64'(first_ce), 64'd29);

    // One more fed sample, then starve the register.
    offer(16'h7f00);
    repeat (3) wait_strobe();
    chk("underrun_sticky", 64'(bus.o_underrun), 64'd1);
    chk("sample_repeated", 64'(bus.o_fft_sample), 64'h7f00);

    // Results before any sync must be ignored.
    feed(1'b0, 1000, 1000);
    feed(1'b0, -1000, 900);

    // Frame 1: most-negative re at bin 3.
    fill_small();
    fr_re[3] = -1024;
    fr_im[3] = 5;
    send_frame(NB, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("frame1_bin", 64'(bus.o_peak_bin), 64'd3);
    chk("frame1_mag", 64'(bus.o_peak_mag), 64'd1029);

    // Frame 2, back to back: tie keeps lowest bin, DC and mirror excluded.
    fill_small();
    fr_re[0]  = 1000;  fr_im[0]  = 0;
    fr_re[2]  = 150;   fr_im[2]  = -50;
    fr_re[5]  = -100;  fr_im[5]  = -100;
    fr_re[12] = 900;   fr_im[12] = 0;
    send_frame(NB, 1'b1);
    chk("sync_err_clean", 64'(bus.o_sync_err), 64'd0);

    // Partial frame interrupted by a sync where bin 7 belongs.
    fill_small();
    fr_re[2] = 1023;
    fr_im[2] = 1023;
    send_frame(7, 1'b0);
    chk("sync_err_before", 64'(bus.o_sync_err), 64'd0);
    fill_small();
    fr_re[6] = 300;
    fr_im[6] = -300;
    fr_re[9] = 1000;
    fr_im[9] = 1000;
    send_frame(NB, 1'b1);
    chk("sync_err_set", 64'(bus.o_sync_err), 64'd1);

    // Disable mid-frame: no report, fftmain back in reset, peak held.
    fill_small();
    fr_re[4] = 1000;
    send_frame(6, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("fft_reset_on_disable", 64'(bus.o_fft_reset), 64'd1);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("peak_bin_held", 64'(bus.o_peak_bin), 64'd6);
    chk("peak_mag_held", 64'(bus.o_peak_mag), 64'd600);
    chk("no_ce_when_idle", 64'(bus.o_fft_ce), 64'd0);
    chk("pending_peaks", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
